// File: rtl/dm_boot_sequencer.sv
// Boot sequencer that drives the debug-module DMI port directly: halts each hart,
// loads DPC with the boot address through an abstract command, resumes, then counts run cycles.
module dm_boot_sequencer #(
  parameter int unsigned NrHarts   = 1,
  parameter logic [63:0] BootAddr  = 64'h0000_0000_8000_0080,
  parameter int unsigned PollLimit = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [63:0] max_cycles_i,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [6:0]  dmi_req_addr_o,
  output logic [1:0]  dmi_req_op_o,
  output logic [31:0] dmi_req_data_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [31:0] dmi_resp_data_i,
  input  logic [1:0]  dmi_resp_resp_i,
  output logic        busy_o,
  output logic        running_o,
  output logic        done_o,
  output logic        error_o,
  output logic [2:0]  err_code_o,
  output logic [9:0]  err_hart_o,
  output logic        timeout_o,
  output logic [63:0] cycles_o
);
  localparam int PW = $clog2(PollLimit + 1);

  localparam logic [1:0] OP_RD = 2'd1;
  localparam logic [1:0] OP_WR = 2'd2;

  localparam logic [6:0] A_DATA0    = 7'h04;
  localparam logic [6:0] A_DATA1    = 7'h05;
  localparam logic [6:0] A_DMCTRL   = 7'h10;
  localparam logic [6:0] A_DMSTATUS = 7'h11;
  localparam logic [6:0] A_ABSCS    = 7'h16;
  localparam logic [6:0] A_COMMAND  = 7'h17;

  localparam logic [2:0] E_RESP = 3'd1;
  localparam logic [2:0] E_POLL = 3'd2;
  localparam logic [2:0] E_CMD  = 3'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_ACTIVATE, S_HALT, S_POLL_HALT, S_DATA0, S_DATA1, S_CMD,
    S_POLL_CMD, S_RESUME, S_POLL_RES, S_CLEAR, S_RUN, S_ERROR
  } state_e;

  state_e        r_state, w_state_nxt;
  logic          r_wait, w_wait_nxt;
  logic [PW-1:0] r_poll, w_poll_nxt;
  logic [9:0]    r_hart, w_hart_nxt;
  logic          r_done, r_error, r_timeout;
  logic [2:0]    r_err_code, w_err_code;
  logic [9:0]    r_err_hart;
  logic [63:0]   r_cycles, w_cycles_nxt;
  logic          w_busy, w_restart, w_set_err, w_poll_miss;
  logic [31:0]   w_hs;
  logic          w_unused;

  assign w_busy    = !(r_state inside {S_IDLE, S_RUN, S_ERROR});
  assign w_restart = start_i && !w_busy;
  assign w_hs      = {6'b0, r_hart, 16'b0};
  assign w_unused  = ^{dmi_resp_data_i[31:18], dmi_resp_data_i[16:13],
                       dmi_resp_data_i[11], dmi_resp_data_i[7:0]};

  // Request phase (r_wait=0) holds valid until accepted; response phase holds ready until valid.
  assign dmi_req_valid_o  = w_busy && !r_wait;
  assign dmi_resp_ready_o = w_busy && r_wait;

  always_comb begin
    dmi_req_addr_o = '0;
    dmi_req_op_o   = '0;
    dmi_req_data_o = '0;
    unique case (r_state)
      S_ACTIVATE:  begin dmi_req_addr_o = A_DMCTRL;   dmi_req_op_o = OP_WR; dmi_req_data_o = 32'h0000_0001; end
      S_HALT:      begin dmi_req_addr_o = A_DMCTRL;   dmi_req_op_o = OP_WR; dmi_req_data_o = 32'h8000_0001 | w_hs; end
      S_POLL_HALT: begin dmi_req_addr_o = A_DMSTATUS; dmi_req_op_o = OP_RD; end
      S_DATA0:     begin dmi_req_addr_o = A_DATA0;    dmi_req_op_o = OP_WR; dmi_req_data_o = BootAddr[31:0]; end
      S_DATA1:     begin dmi_req_addr_o = A_DATA1;    dmi_req_op_o = OP_WR; dmi_req_data_o = BootAddr[63:32]; end
      S_CMD:       begin dmi_req_addr_o = A_COMMAND;  dmi_req_op_o = OP_WR; dmi_req_data_o = 32'h0033_07B1; end
      S_POLL_CMD:  begin dmi_req_addr_o = A_ABSCS;    dmi_req_op_o = OP_RD; end
      S_RESUME:    begin dmi_req_addr_o = A_DMCTRL;   dmi_req_op_o = OP_WR; dmi_req_data_o = 32'h4000_0001 | w_hs; end
      S_POLL_RES:  begin dmi_req_addr_o = A_DMSTATUS; dmi_req_op_o = OP_RD; end
      S_CLEAR:     begin dmi_req_addr_o = A_DMCTRL;   dmi_req_op_o = OP_WR; dmi_req_data_o = 32'h0000_0001 | w_hs; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_poll_nxt  = r_poll;
    w_hart_nxt  = r_hart;
    w_set_err   = 1'b0;
    w_err_code  = '0;
    w_poll_miss = 1'b0;
    if (w_restart) begin
      w_state_nxt = S_ACTIVATE;
      w_wait_nxt  = 1'b0;
      w_poll_nxt  = '0;
      w_hart_nxt  = '0;
    end else if (w_busy) begin
      if (!r_wait) begin
        if (dmi_req_ready_i) w_wait_nxt = 1'b1;
      end else if (dmi_resp_valid_i) begin
        w_wait_nxt = 1'b0;
        if (dmi_resp_resp_i != 2'd0) begin
          w_set_err  = 1'b1;
          w_err_code = E_RESP;
        end else begin
          unique case (r_state)
            S_ACTIVATE:  w_state_nxt = S_HALT;
            S_HALT:      begin w_state_nxt = S_POLL_HALT; w_poll_nxt = '0; end
            S_POLL_HALT: if (dmi_resp_data_i[9]) w_state_nxt = S_DATA0; else w_poll_miss = 1'b1;
            S_DATA0:     w_state_nxt = S_DATA1;
            S_DATA1:     w_state_nxt = S_CMD;
            S_CMD:       begin w_state_nxt = S_POLL_CMD; w_poll_nxt = '0; end
            S_POLL_CMD: begin
              if (dmi_resp_data_i[12]) w_poll_miss = 1'b1;
              else if (dmi_resp_data_i[10:8] != 3'd0) begin
                w_set_err  = 1'b1;
                w_err_code = E_CMD;
              end else w_state_nxt = S_RESUME;
            end
            S_RESUME:    begin w_state_nxt = S_POLL_RES; w_poll_nxt = '0; end
            S_POLL_RES:  if (dmi_resp_data_i[17]) w_state_nxt = S_CLEAR; else w_poll_miss = 1'b1;
            S_CLEAR: begin
              if (r_hart == 10'(NrHarts - 1)) w_state_nxt = S_RUN;
              else begin
                w_hart_nxt  = r_hart + 10'd1;
                w_state_nxt = S_HALT;
              end
            end
            default: ;
          endcase
          if (w_poll_miss) begin
            if (r_poll == PW'(PollLimit - 1)) begin
              w_set_err  = 1'b1;
              w_err_code = E_POLL;
            end else w_poll_nxt = r_poll + PW'(1);
          end
        end
        if (w_set_err) w_state_nxt = S_ERROR;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_wait  <= 1'b0;
      r_poll  <= '0;
      r_hart  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_poll  <= w_poll_nxt;
      r_hart  <= w_hart_nxt;
    end
  end

  assign w_cycles_nxt = (&r_cycles) ? r_cycles : r_cycles + 64'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= '0;
      r_err_hart <= '0;
      r_timeout  <= 1'b0;
      r_cycles   <= '0;
    end else if (w_restart) begin
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= '0;
      r_err_hart <= '0;
      r_timeout  <= 1'b0;
      r_cycles   <= '0;
    end else begin
      if (w_set_err) begin
        r_error    <= 1'b1;
        r_err_code <= w_err_code;
        r_err_hart <= r_hart;
      end
      if (w_state_nxt == S_RUN && r_state != S_RUN) r_done <= 1'b1;
      // Timeout is judged on the incoming count so it rises with the count that exceeds the limit.
      if (r_state == S_RUN) begin
        r_cycles <= w_cycles_nxt;
        if (max_cycles_i != 64'd0 && w_cycles_nxt > max_cycles_i) r_timeout <= 1'b1;
      end
    end
  end

  assign busy_o     = w_busy;
  assign running_o  = (r_state == S_RUN);
  assign done_o     = r_done;
  assign error_o    = r_error;
  assign err_code_o = r_err_code;
  assign err_hart_o = r_err_hart;
  assign timeout_o  = r_timeout;
  assign cycles_o   = r_cycles;

endmodule

// File: tb/tb_dm_boot_sequencer.sv
// Directed bench for dm_boot_sequencer: a reactive debug-module model answers DMI traffic,
// expected request streams and error outcomes come from hand-built tables.
module tb_dm_boot_sequencer;
  localparam int NH = 3;
  localparam int PL = 16;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } req_t;

  typedef struct {
    bit          halt_never;
    logic [2:0]  cmderr;
    int          cmderr_hart;
    bit          fail_en;
    logic [6:0]  fail_addr;
    bit          exp_err;
    bit          exp_done;
    logic [2:0]  exp_code;
    logic [9:0]  exp_hart;
    int          exp_nreq;
  } row_t;

  logic        clk, rst_n, start;
  logic [63:0] max_cycles;
  logic        req_valid, req_ready;
  logic [6:0]  req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_resp;
  logic        busy, running, done, error, timeout;
  logic [2:0]  err_code;
  logic [9:0]  err_hart;
  logic [63:0] cycles;

  int errors = 0;
  int checks = 0;

  // debug-module model state and fault knobs
  bit          stall_en, halt_never, fail_en, cmd_busy;
  logic [2:0]  cmderr_val;
  int          cmderr_hart, sel;
  logic [6:0]  fail_addr;
  bit          halted[NH], rack[NH];
  logic [63:0] dpc[NH];
  logic [31:0] d0, d1;
  req_t        log_q[$];
  req_t        exp_q[$];

  dm_boot_sequencer #(.NrHarts(NH), .BootAddr(64'h0000_0000_8000_0080), .PollLimit(PL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .max_cycles_i(max_cycles),
    .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready), .dmi_req_addr_o(req_addr),
    .dmi_req_op_o(req_op), .dmi_req_data_o(req_data),
    .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
    .dmi_resp_data_i(resp_data), .dmi_resp_resp_i(resp_resp),
    .busy_o(busy), .running_o(running), .done_o(done), .error_o(error),
    .err_code_o(err_code), .err_hart_o(err_hart), .timeout_o(timeout), .cycles_o(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic [6:0] a, input logic [1:0] o, input logic [31:0] d);
    req_t r;
    r.addr = a; r.op = o; r.data = d;
    return r;
  endfunction

  task automatic dm_clear();
    for (int h = 0; h < NH; h++) begin halted[h] = 0; rack[h] = 0; dpc[h] = '0; end
    sel = 0; cmd_busy = 0; d0 = '0; d1 = '0;
    log_q.delete();
  endtask

  task automatic serve(input req_t r, output logic [31:0] d, output logic [1:0] rs);
    d = '0; rs = 2'd0;
    if (r.op == 2'd2) begin
      if (fail_en && r.addr == fail_addr) rs = 2'd2;
      else case (r.addr)
        7'h10: begin
          sel = int'(r.data[25:16]);
          if (sel < NH) begin
            if (r.data[31] && !halt_never) begin halted[sel] = 1; rack[sel] = 0; end
            if (r.data[30]) begin halted[sel] = 0; rack[sel] = 1; end
          end
        end
        7'h04: d0 = r.data;
        7'h05: d1 = r.data;
        7'h17: begin
          if (r.data[17] && r.data[16] && sel < NH) dpc[sel] = {d1, d0};
          cmd_busy = 1;
        end
        default: ;
      endcase
    end else if (sel < NH) begin
      case (r.addr)
        7'h11: d = {14'b0, rack[sel], 7'b0, halted[sel], 9'b0};
        7'h16: begin
          if (cmd_busy) begin d = 32'h0000_1000; cmd_busy = 0; end
          else d = {21'b0, (sel == cmderr_hart) ? cmderr_val : 3'b0, 8'b0};
        end
        default: ;
      endcase
    end
  endtask

  // Inputs change on the falling edge; DUT outputs only move on the rising edge,
  // so what is seen here is exactly what the next rising edge samples.
  initial begin : dm_model
    bit          rv_fire, pend, held;
    logic [31:0] pd;
    logic [1:0]  pr;
    int          stall;
    req_t        snap, cur;
    rv_fire = 0; pend = 0; held = 0; stall = 0; pd = '0; pr = '0; snap = '0;
    req_ready = 0; resp_valid = 0; resp_data = '0; resp_resp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_ready = 0; resp_valid = 0; rv_fire = 0; pend = 0; held = 0; stall = 0;
        continue;
      end
      if (rv_fire) begin resp_valid = 0; rv_fire = 0; end
      if (pend && !resp_valid) begin
        resp_valid = 1; resp_data = pd; resp_resp = pr; pend = 0;
      end
      if (resp_valid && resp_ready) rv_fire = 1;
      cur = mk(req_addr, req_op, req_data);
      if (req_valid) begin
        if (held) chk("req_stable", cur, snap);
        if (stall > 0) begin
          req_ready = 0; stall--; held = 1; snap = cur;
        end else begin
          req_ready = 1; held = 0;
          log_q.push_back(cur);
          serve(cur, pd, pr);
          pend = 1;
          stall = stall_en ? int'($urandom_range(0, 5)) : 0;
        end
      end else begin
        req_ready = 0; held = 0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_end();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (running || error) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("wait_end_bound", ok, 1'b1);
  endtask

  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back(mk(7'h10, 2'd2, 32'h0000_0001));
    for (int h = 0; h < NH; h++) begin
      logic [31:0] hs;
      hs = 32'(h) << 16;
      exp_q.push_back(mk(7'h10, 2'd2, 32'h8000_0001 | hs));
      exp_q.push_back(mk(7'h11, 2'd1, 32'h0));
      exp_q.push_back(mk(7'h04, 2'd2, 32'h8000_0080));
      exp_q.push_back(mk(7'h05, 2'd2, 32'h0000_0000));
      exp_q.push_back(mk(7'h17, 2'd2, 32'h0033_07B1));
      exp_q.push_back(mk(7'h16, 2'd1, 32'h0));
      exp_q.push_back(mk(7'h16, 2'd1, 32'h0));
      exp_q.push_back(mk(7'h10, 2'd2, 32'h4000_0001 | hs));
      exp_q.push_back(mk(7'h11, 2'd1, 32'h0));
      exp_q.push_back(mk(7'h10, 2'd2, 32'h0000_0001 | hs));
    end
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_nreq"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s_addr[%0d]", tag, i), log_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_op[%0d]", tag, i), log_q[i].op, exp_q[i].op);
      if (exp_q[i].op == 2'd2)
        chk($sformatf("%s_data[%0d]", tag, i), log_q[i].data, exp_q[i].data);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {req_valid, resp_ready, busy, running, done, error, timeout,
            err_code, err_hart, cycles, req_addr, req_op, req_data};
  endfunction

  row_t rows[6];

  initial begin : main
    rows[0] = '{1, 3'd0, 0, 0, 7'h00, 1, 0, 3'd2, 10'd0, 18};
    rows[1] = '{0, 3'd2, 0, 0, 7'h00, 1, 0, 3'd3, 10'd0, 8};
    rows[2] = '{0, 3'd2, 1, 0, 7'h00, 1, 0, 3'd3, 10'd1, 18};
    rows[3] = '{0, 3'd0, 0, 1, 7'h05, 1, 0, 3'd1, 10'd0, 5};
    rows[4] = '{0, 3'd0, 0, 1, 7'h10, 1, 0, 3'd1, 10'd0, 1};
    rows[5] = '{0, 3'd0, 0, 0, 7'h00, 0, 1, 3'd0, 10'd0, 31};

    rst_n = 0; start = 0; max_cycles = 64'd100;
    stall_en = 1; halt_never = 0; fail_en = 0; fail_addr = '0; cmderr_val = '0; cmderr_hart = 0;
    dm_clear();
    build_exp();

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), '0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_outputs", all_outs(), '0);

    // full three-hart boot with random ready stalls; a mid-sequence start must be ignored
    pulse_start();
    chk("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 500 && log_q.size() < 4; i++) @(negedge clk);
    pulse_start();
    wait_end();
    chk("main_running", running, 1'b1);
    chk("main_done", done, 1'b1);
    chk("main_error", error, 1'b0);
    chk("main_busy", busy, 1'b0);
    chk("main_cycles0", cycles, 64'd0);
    cmp_log("main");
    for (int h = 0; h < NH; h++) chk($sformatf("dpc[%0d]", h), dpc[h], 64'h8000_0080);
    repeat (100) @(negedge clk);
    chk("cycles_100", cycles, 64'd100);
    chk("timeout_at_100", timeout, 1'b0);
    @(negedge clk);
    chk("cycles_101", cycles, 64'd101);
    chk("timeout_at_101", timeout, 1'b1);

    // fault table: each row restarts from RUN/ERROR
    max_cycles = 64'd0;
    for (int r = 0; r < 6; r++) begin
      dm_clear();
      halt_never = rows[r].halt_never; cmderr_val = rows[r].cmderr;
      cmderr_hart = rows[r].cmderr_hart; fail_en = rows[r].fail_en; fail_addr = rows[r].fail_addr;
      pulse_start();
      chk($sformatf("row%0d_busy", r), busy, 1'b1);
      chk($sformatf("row%0d_cleared", r), {done, error, timeout, cycles}, '0);
      wait_end();
      repeat (20) @(negedge clk);
      chk($sformatf("row%0d_nreq", r), log_q.size(), rows[r].exp_nreq);
      chk($sformatf("row%0d_error", r), error, rows[r].exp_err);
      chk($sformatf("row%0d_done", r), done, rows[r].exp_done);
      chk($sformatf("row%0d_code", r), err_code, rows[r].exp_code);
      chk($sformatf("row%0d_hart", r), err_hart, rows[r].exp_hart);
      chk($sformatf("row%0d_reqvalid", r), req_valid, 1'b0);
    end
    cmp_log("nostall");
    // row 5 ended in RUN 20 cycles ago; with a zero limit the timeout never fires
    repeat (200) @(negedge clk);
    chk("cycles_220", cycles, 64'd220);
    chk("timeout_disabled", timeout, 1'b0);

    // asynchronous reset while polling for halt
    dm_clear();
    halt_never = 1; fail_en = 0; cmderr_val = '0;
    pulse_start();
    for (int i = 0; i < 500 && log_q.size() < 4; i++) @(negedge clk);
    chk("poll_reached", log_q.size() >= 4, 1'b1);
    #2 rst_n = 0;
    #1 chk("reset_mid_poll", all_outs(), '0);
    @(negedge clk);
    rst_n = 1;
    dm_clear();
    halt_never = 0;
    pulse_start();
    wait_end();
    chk("after_reset_done", {done, error}, 2'b10);
    chk("after_reset_nreq", log_q.size(), 31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_boot_sequencer.md
Name: dm_boot_sequencer

Overview:
- Synthesizable on-chip successor to bench-driven JTAG boot flows.
- Issues Debug Module Interface (DMI) requests directly to the debug module, for NrHarts harts in turn: activate DM, halt hart, write DPC with a boot address through an abstract command, then resume.
- After all harts resume, counts run cycles and flags a cycle-limit timeout.
- Sits between the SoC boot/test logic and the dm_top DMI port, in place of the dmi_jtag path.

Parameters:
- NrHarts, 1, number of harts booted sequentially; hartsel = 0..NrHarts-1.
- BootAddr, 64'h0000_0000_8000_0080, value written to DPC.
- PollLimit, 16, maximum status reads per poll phase before error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  1-cycle pulse; starts sequence when idle
- max_cycles_i  in  64  run-cycle limit; 0 disables timeout
- dmi_req_valid_o  out  1  DMI request valid
- dmi_req_ready_i  in  1  DMI request accepted
- dmi_req_addr_o  out  7  DMI register address
- dmi_req_op_o  out  2  1 = read, 2 = write
- dmi_req_data_o  out  32  write data
- dmi_resp_valid_i  in  1  DMI response valid
- dmi_resp_ready_o  out  1  ready for response
- dmi_resp_data_i  in  32  read data
- dmi_resp_resp_i  in  2  0 = success, else failure
- busy_o  out  1  sequence in progress
- running_o  out  1  all harts resumed; cycle counter active
- done_o  out  1  sticky: sequence finished without error
- error_o  out  1  sticky error
- err_code_o  out  3  1 = DMI resp fail, 2 = poll limit, 3 = cmderr != 0
- err_hart_o  out  10  hart index at error
- timeout_o  out  1  sticky: cycles_o exceeded max_cycles_i
- cycles_o  out  64  run-cycle count

Behaviour:
- Reset: all outputs 0, FSM in IDLE, hart index 0, counters 0. Reset asserted mid-transaction drops dmi_req_valid_o immediately. An in-flight DMI response is not awaited.
- Transaction unit:
  - Drive req fields with valid = 1 and hold them stable until valid & ready.
  - In the following cycles hold dmi_resp_ready_o = 1 until dmi_resp_valid_i.
  - Only one outstanding request at a time.
  - Response with resp != 0 -> ERROR, err_code 1.
- FSM steps per hart h (hs = h << 16 in dmcontrol):
  - ACTIVATE: write 0x10 = 0x0000_0001 (first hart only).
  - HALT: write 0x10 = 0x8000_0001 | hs.
  - POLL_HALT: read 0x11 until bit 9 (allhalted) = 1.
  - DATA0: write 0x04 = BootAddr[31:0].
  - DATA1: write 0x05 = BootAddr[63:32].
  - CMD: write 0x17 = 0x0033_07B1 (aarsize 3, transfer, write, regno DPC).
  - POLL_CMD: read 0x16 until bit 12 (busy) = 0. Then bits 10:8 != 0 -> ERROR, code 3.
  - RESUME: write 0x10 = 0x4000_0001 | hs.
  - POLL_RES: read 0x11 until bit 17 (allresumeack) = 1.
  - Then clear request: write 0x10 = 0x0000_0001 | hs.
  - h == NrHarts-1 -> RUN; otherwise h++ and go to HALT.
- Poll counter resets on entry to each poll state. The read whose response makes PollLimit unsatisfied reads -> ERROR, code 2.
- busy_o = 1 from the cycle after start_i until RUN or ERROR.
- RUN:
  - running_o = 1 and done_o = 1.
  - cycles_o increments every cycle and saturates at all-ones.
  - When max_cycles_i != 0 and cycles_o > max_cycles_i, timeout_o sets (sticky). Counting continues.
- ERROR: terminal. dmi_req_valid_o = 0; error_o, err_code_o, err_hart_o hold.
- start_i:
  - Ignored unless in IDLE.
  - In RUN or ERROR, start_i restarts from ACTIVATE and clears done, error, timeout and cycles.
  - start_i during a pending request is ignored.
- Simultaneous ready and resp_valid in the same cycle as the request are not legal; the response is sampled no earlier than the cycle after acceptance.

Test Plan:
- NrHarts=1, responsive DM model, start_i -> exact request sequence 0x10 W 0x1, 0x10 W 0x8000_0001, 0x11 R, 0x04 W 0x8000_0080, 0x05 W 0, 0x17 W 0x0033_07B1, 0x16 R, 0x10 W 0x4000_0001, 0x11 R, 0x10 W 0x1; then done_o = 1, running_o = 1.
- NrHarts=3 -> three halt/DPC/resume blocks with dmcontrol hartsel fields 0x0, 0x1_0000, 0x2_0000; DPC model holds 0x8000_0080 per hart.
- Random dmi_req_ready_i stalls (0-5 cycles) -> req fields stable while valid & !ready; identical final state.
- dmstatus never halted, PollLimit=16 -> 16 reads of 0x11, then error_o = 1, err_code_o = 2, err_hart_o = 0, no further requests.
- abstractcs returns cmderr = 2 -> err_code_o = 3. Separately, a resp = 2 on any write -> err_code_o = 1.
- max_cycles_i = 100 -> timeout_o rises when cycles_o = 101. With max_cycles_i = 0, never. Reset asserted mid-POLL_HALT -> all outputs 0 in the same cycle.
